// File: rtl/fwd_arb_pkg.sv
// Shared types and helpers for the forwarder-side arbiter.
package fwd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam int MODE_FIXED   = 0;
  localparam int MODE_RR      = 1;
  localparam int MODE_ORDERED = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width never drops below one bit, so N = 1 still has a legal select.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fwd_rr_arb_rr_pick.sv
// Combinational candidate picker: fixed priority, rotating priority from ptr, or ptr-only.
module rr_pick
  import fwd_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic [1:0]    mode,
  output logic          found,
  output logic [SW-1:0] idx
);

  always_comb begin
    int base;
    int j;
    found = 1'b0;
    idx   = '0;
    base  = 0;
    j     = 0;
    if (mode == 2'(MODE_ORDERED)) begin
      found = req[ptr];
      idx   = ptr;
    end else begin
      if (mode == 2'(MODE_RR)) base = int'(ptr);
      for (int k = 0; k < N; k++) begin
        j = base + k;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          found = 1'b1;
          idx   = j[SW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_rr_arb.sv
// Arbitrates N packet-filter cores onto one forwarder: offer/ack handshake, hold until done,
// and return read data through an RD_LAT-deep registered mux.
module fwd_rr_arb
  import fwd_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int PLEN_WIDTH = 32,
  parameter int MODE       = 0,
  parameter int RD_LAT     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_vld,
  output logic [PLEN_WIDTH-1:0]   byte_len,
  input  logic                    done,
  output logic                    rdy,
  input  logic                    ack,
  output logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic [N-1:0]            fwd_rd_en,
  input  logic [N*DATA_WIDTH-1:0] fwd_rd_data,
  input  logic [N-1:0]            fwd_rd_data_vld,
  input  logic [N*PLEN_WIDTH-1:0] fwd_byte_len,
  output logic [N-1:0]            fwd_done,
  input  logic [N-1:0]            rdy_for_fwd,
  output logic [N-1:0]            rdy_for_fwd_ack
);

  localparam int SW = sel_w(N);

  state_t                state, state_nxt;
  logic [SW-1:0]         sel, ptr, pick_idx, sel_inc;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] mux_dat, pipe_dat;
  logic                  mux_vld, pipe_vld;
  logic [PLEN_WIDTH-1:0] sel_len;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req   (rdy_for_fwd),
    .ptr   (ptr),
    .mode  (2'(MODE)),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_inc  = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
  assign sel_len  = fwd_byte_len[int'(sel)*PLEN_WIDTH +: PLEN_WIDTH];
  assign fwd_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_found) sel <= pick_idx;
      if (state == ST_BUSY && done && MODE != MODE_FIXED) ptr <= sel_inc;
    end
  end

  // Handshake outputs are forced low while rst is held, even before the state register clears.
  always_comb begin
    state_nxt       = state;
    rdy             = 1'b0;
    byte_len        = '0;
    fwd_rd_en       = '0;
    fwd_done        = '0;
    rdy_for_fwd_ack = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) state_nxt = ST_OFFER;
      end
      ST_OFFER: begin
        rdy      = 1'b1;
        byte_len = sel_len;
        if (ack) begin
          rdy_for_fwd_ack[sel] = 1'b1;
          state_nxt            = ST_BUSY;
        end else if (!rdy_for_fwd[sel]) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        byte_len       = sel_len;
        fwd_rd_en[sel] = rd_en;
        fwd_done[sel]  = done;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) begin
      rdy             = 1'b0;
      byte_len        = '0;
      fwd_rd_en       = '0;
      fwd_done        = '0;
      rdy_for_fwd_ack = '0;
    end
  end

  assign mux_dat = fwd_rd_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign mux_vld = fwd_rd_data_vld[sel] && (state == ST_BUSY);

  generate
    if (RD_LAT == 0) begin : g_no_pipe
      assign pipe_dat = mux_dat;
      assign pipe_vld = mux_vld;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] dat_q [RD_LAT];
      logic [RD_LAT-1:0]     vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
          vld_q <= '0;
        end else begin
          dat_q[0] <= mux_dat;
          vld_q[0] <= mux_vld;
          for (int i = 1; i < RD_LAT; i++) begin
            dat_q[i] <= dat_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
      assign pipe_dat = dat_q[RD_LAT-1];
      assign pipe_vld = vld_q[RD_LAT-1];
    end
  endgenerate

  assign rd_data     = rst ? '0 : pipe_dat;
  assign rd_data_vld = pipe_vld & ~rst;

endmodule

// File: tb/tb_fwd_rr_arb.sv
// Three arbiters (fixed/RD_LAT2, round-robin/RD_LAT0, in-order/RD_LAT1) driven by directed
// sequences; expected events go to a scoreboard that a negedge monitor drains.
module tb_fwd_rr_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int PW = 32;
  localparam int NG = 3;

  localparam int K_OFFER = 0;
  localparam int K_ACK   = 1;
  localparam int K_DONE  = 2;
  localparam int K_RDEN  = 3;
  localparam int K_RDV   = 4;

  typedef struct {
    int          g;
    int          kind;
    logic [63:0] val;
    int          at;
  } ev_t;

  ev_t sbq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [AW-1:0]   addr    [NG];
  logic            rd_en   [NG];
  logic            done    [NG];
  logic            ack     [NG];
  logic [N-1:0]    rff     [NG];
  logic [N-1:0]    frv     [NG];
  logic [N*DW-1:0] frd     [NG];
  logic [DW-1:0]   rd_data [NG];
  logic            rdv     [NG];
  logic [PW-1:0]   blen    [NG];
  logic            rdy     [NG];
  logic [AW-1:0]   faddr   [NG];
  logic [N-1:0]    frde    [NG];
  logic [N-1:0]    fdone   [NG];
  logic [N-1:0]    fack    [NG];
  bit              rdy_prev[NG];
  logic [N*PW-1:0] fblen = {32'h103, 32'h102, 32'h101, 32'h100};

  generate
    for (genvar g = 0; g < NG; g++) begin : g_dut
      fwd_rr_arb #(
        .N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW),
        .MODE(g), .RD_LAT((g == 0) ? 2 : g - 1)
      ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr[g]),
        .rd_en           (rd_en[g]),
        .rd_data         (rd_data[g]),
        .rd_data_vld     (rdv[g]),
        .byte_len        (blen[g]),
        .done            (done[g]),
        .rdy             (rdy[g]),
        .ack             (ack[g]),
        .fwd_addr        (faddr[g]),
        .fwd_rd_en       (frde[g]),
        .fwd_rd_data     (frd[g]),
        .fwd_rd_data_vld (frv[g]),
        .fwd_byte_len    (fblen),
        .fwd_done        (fdone[g]),
        .rdy_for_fwd     (rff[g]),
        .rdy_for_fwd_ack (fack[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic string kname(int k);
    case (k)
      K_OFFER: return "offer";
      K_ACK:   return "ack";
      K_DONE:  return "done";
      K_RDEN:  return "rd_en";
      default: return "rd_vld";
    endcase
  endfunction

  function automatic int lat(int g);
    return (g == 0) ? 2 : g - 1;
  endfunction

  task automatic push(int g, int kind, logic [63:0] val, int at);
    ev_t e;
    e.g = g; e.kind = kind; e.val = val; e.at = at;
    sbq.push_back(e);
  endtask

  task automatic observe(int g, int kind, logic [63:0] val);
    int hit = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (hit < 0 && sbq[i].g == g && sbq[i].kind == kind) hit = i;
    checks++;
    if (hit < 0) begin
      errors++;
      $display("FAIL dut%0d %s unexpected: got 0x%0h at cycle %0d, required none", g, kname(kind), val, cyc);
    end else begin
      if (sbq[hit].val !== val || sbq[hit].at != cyc) begin
        errors++;
        $display("FAIL dut%0d %s: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                 g, kname(kind), val, cyc, sbq[hit].val, sbq[hit].at);
      end
      sbq.delete(hit);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NG; g++) begin
      if (rdy[g] && !rdy_prev[g]) observe(g, K_OFFER, 64'(blen[g]));
      if (fack[g] != '0)  observe(g, K_ACK,  64'(fack[g]));
      if (fdone[g] != '0) observe(g, K_DONE, 64'(fdone[g]));
      if (frde[g] != '0)  observe(g, K_RDEN, 64'({faddr[g], frde[g]}));
      if (rdv[g])         observe(g, K_RDV,  rd_data[g]);
      rdy_prev[g] = rdy[g];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet(int g, string tag);
    chk($sformatf("%s dut%0d rdy", tag, g), 64'(rdy[g]), 0);
    chk($sformatf("%s dut%0d rd_data_vld", tag, g), 64'(rdv[g]), 0);
    chk($sformatf("%s dut%0d rd_data", tag, g), rd_data[g], 0);
    chk($sformatf("%s dut%0d byte_len", tag, g), 64'(blen[g]), 0);
    chk($sformatf("%s dut%0d fwd_rd_en", tag, g), 64'(frde[g]), 0);
    chk($sformatf("%s dut%0d fwd_done", tag, g), 64'(fdone[g]), 0);
    chk($sformatf("%s dut%0d rdy_for_fwd_ack", tag, g), 64'(fack[g]), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(int g, logic [N-1:0] v, int core);
    rff[g] = v;
    push(g, K_OFFER, 64'h100 + 64'(core), cyc + 1);
    step();
  endtask

  task automatic accept(int g, int core, bit drop);
    ack[g] = 1'b1;
    if (drop) rff[g][core] = 1'b0;
    push(g, K_ACK, 64'(1 << core), cyc);
    step();
    ack[g] = 1'b0;
  endtask

  task automatic finish(int g, int core);
    done[g] = 1'b1;
    push(g, K_DONE, 64'(1 << core), cyc);
    step();
    done[g] = 1'b0;
  endtask

  task automatic rd(int g, int core, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [N-1:0] oh;
    oh = N'(1 << core);
    rd_en[g] = 1'b1;
    addr[g]  = a;
    frv[g][core] = 1'b1;
    frd[g][core*DW +: DW] = d;
    push(g, K_RDEN, 64'({a, oh}), cyc);
    push(g, K_RDV, d, cyc + lat(g));
    step();
    rd_en[g] = 1'b0;
    frv[g]   = '0;
  endtask

  initial begin
    for (int g = 0; g < NG; g++) begin
      addr[g] = '0; rd_en[g] = 1'b0; done[g] = 1'b0; ack[g] = 1'b0;
      rff[g] = '0; frv[g] = '0; frd[g] = '0;
    end
    step();
    step();
    for (int g = 0; g < NG; g++) quiet(g, "reset");
    rst = 1'b0;
    step();

    // Fixed priority: 1010 picks core 1, then core 3 once core 1 is released.
    offer(0, 4'b1010, 1);
    accept(0, 1, 1'b1);
    finish(0, 1);
    offer(0, 4'b1000, 3);
    accept(0, 3, 1'b1);
    rd(0, 3, 8'h5A, 64'hDEAD_BEEF);
    frv[0][1] = 1'b1;
    frd[0][1*DW +: DW] = 64'h1111;
    step();
    frv[0] = '0;
    finish(0, 3);
    // Outside BUSY: reads and core valids must not leak through.
    rd_en[0] = 1'b1;
    addr[0]  = 8'h33;
    frv[0][3] = 1'b1;
    frd[0][3*DW +: DW] = 64'hBAD0;
    step();
    chk("idle fwd_addr", 64'(faddr[0]), 64'h33);
    step();
    step();
    rd_en[0] = 1'b0;
    frv[0]   = '0;
    step();
    step();

    // ack with nothing on offer, withdrawn offer, then ack together with done.
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    chk("stray ack rdy", 64'(rdy[0]), 0);
    offer(0, 4'b0010, 1);
    rff[0] = '0;
    step();
    chk("withdrawn rdy", 64'(rdy[0]), 0);
    offer(0, 4'b0010, 1);
    done[0] = 1'b1;
    accept(0, 1, 1'b1);
    done[0] = 1'b0;
    finish(0, 1);

    // Round-robin: all four held ready for eight packets.
    rff[1] = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      offer(1, 4'b1111, k % 4);
      accept(1, k % 4, 1'b0);
      if (k == 2) rd(1, 2, 8'hA5, 64'h0123_4567_89AB_CDEF);
      finish(1, k % 4);
    end
    offer(1, 4'b0010, 1);
    accept(1, 1, 1'b1);
    finish(1, 1);
    offer(1, 4'b0011, 0);
    accept(1, 0, 1'b1);

    // In-order rotation: walk ptr to 2, then only core 2 may be offered.
    offer(2, 4'b0001, 0);
    accept(2, 0, 1'b1);
    finish(2, 0);
    offer(2, 4'b0010, 1);
    accept(2, 1, 1'b1);
    rd(2, 1, 8'h11, 64'hCAFE);
    finish(2, 1);
    rff[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ordered blocked rdy %0d", k), 64'(rdy[2]), 0);
    end
    offer(2, 4'b0101, 2);
    accept(2, 2, 1'b1);
    finish(2, 2);
    rff[2] = '0;

    // Reset with dut0 and dut1 in BUSY and a read in flight on dut0.
    offer(0, 4'b0100, 2);
    accept(0, 2, 1'b1);
    rd_en[0] = 1'b1;
    addr[0]  = 8'h77;
    frv[0][2] = 1'b1;
    frd[0][2*DW +: DW] = 64'h7777_0000;
    push(0, K_RDEN, 64'({8'h77, 4'b0100}), cyc);
    step();
    frv[0] = '0;
    rst = 1'b1;
    for (int g = 0; g < NG; g++) begin
      rff[g] = '0; done[g] = 1'b1; rd_en[g] = 1'b1;
    end
    #1;
    quiet(0, "in reset");
    quiet(1, "in reset");
    step();
    rst = 1'b0;
    for (int g = 0; g < NG; g++) begin
      done[g] = 1'b0; rd_en[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < NG; g++) quiet(g, "post reset");
    step();
    chk("flushed rd_data_vld", 64'(rdv[0]), 0);
    chk("flushed rd_data", rd_data[0], 0);
    rff[1] = 4'b1110;
    rff[2] = 4'b0001;
    push(1, K_OFFER, 64'h101, cyc + 1);
    push(2, K_OFFER, 64'h100, cyc + 1);
    step();
    accept(1, 1, 1'b1);
    accept(2, 0, 1'b1);
    rff[1] = '0;
    rff[2] = '0;
    finish(1, 1);
    finish(2, 0);

    step();
    step();
    step();
    chk("scoreboard pending", 64'(sbq.size()), 0);
    foreach (sbq[i])
      $display("pending dut%0d %s 0x%0h at cycle %0d", sbq[i].g, kname(sbq[i].kind), sbq[i].val, sbq[i].at);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_rr_arb.md
Name: fwd_rr_arb

Overview:
- Successor forwarder-side arbiter between N packetfilter_cores and one forwarder.
- Selects one ready core by a configurable policy and runs the rdy/ack handshake with the forwarder.
- Holds the selected core until `done`, and routes read traffic through a muxed read path with parametrised latency.
- Adds over the previous arbiter: round-robin fairness, strict in-order mode, per-core rd_en gating, and a registered read pipeline.

Parameters:
- N, 4: number of packetfilter_cores; 1..64.
- ADDR_WIDTH, 8: forwarder read address width.
- DATA_WIDTH, 64: read data width.
- PLEN_WIDTH, 32: packet byte-length width.
- MODE, 0: selection policy. 0 = fixed priority, lowest index wins. 1 = round-robin. 2 = strict in-order rotation.
- RD_LAT, 0: extra register stages on the read-data return path; 0..2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  forwarder read address
- rd_en  in  1  forwarder read enable
- rd_data  out  DATA_WIDTH  read data from the selected core
- rd_data_vld  out  1  rd_data valid
- byte_len  out  PLEN_WIDTH  byte length of the selected packet
- done  in  1  forwarder finished with the current packet
- rdy  out  1  a packet is on offer
- ack  in  1  forwarder accepts the offer
- fwd_addr  out  ADDR_WIDTH  broadcast address to the cores
- fwd_rd_en  out  N  one-hot read enable, asserted only for the selected core
- fwd_rd_data  in  N*DATA_WIDTH  core read data, core i at slice i
- fwd_rd_data_vld  in  N  per-core read data valid
- fwd_byte_len  in  N*PLEN_WIDTH  per-core byte length
- fwd_done  out  N  one-hot done pulse to the selected core
- rdy_for_fwd  in  N  core i holds a packet ready to forward
- rdy_for_fwd_ack  out  N  one-hot handshake acknowledge to a core

Behaviour:
- States: IDLE, OFFER, BUSY.
- Registers: sel (CLOG2(N) bits), ptr (CLOG2(N) bits).
- Reset: state = IDLE; sel = 0; ptr = 0; read pipeline cleared. While in reset, rdy, rd_data_vld, fwd_rd_en, fwd_done and rdy_for_fwd_ack are all 0. rd_data and byte_len are 0.
- IDLE:
  - The candidate is chosen combinationally from rdy_for_fwd.
  - MODE 0: lowest set index.
  - MODE 1: first set index at or above ptr, wrapping modulo N.
  - MODE 2: only core ptr is eligible.
  - If a candidate exists, sel <= candidate and the next state is OFFER.
  - Latency: rdy asserts 1 cycle after rdy_for_fwd rises.
- OFFER:
  - rdy = 1.
  - byte_len = fwd_byte_len[sel], driven combinationally.
  - If ack = 1: rdy_for_fwd_ack[sel] = 1 in that same cycle (combinational, one cycle only); next state is BUSY.
  - If ack = 0 and rdy_for_fwd[sel] has dropped: return to IDLE; no ack is issued.
  - `done` is ignored in OFFER.
- BUSY:
  - rdy = 0.
  - fwd_addr = addr at all times, in every state.
  - fwd_rd_en[sel] = rd_en; all other bits are 0.
  - fwd_done[sel] = done.
  - When done = 1: next state is IDLE, and ptr <= (sel+1) mod N in MODE 1/2. ptr is not changed in MODE 0.
  - A new offer needs at least 1 IDLE cycle after done.
- Read path:
  - {rd_data, rd_data_vld} = mux of the fwd_rd_data / fwd_rd_data_vld slices at sel, delayed by RD_LAT register stages.
  - The valid bit is ANDed with (state == BUSY) before the pipeline.
  - Total latency from a core's valid to rd_data_vld = RD_LAT cycles.
- Outside BUSY, rd_en is ignored; fwd_rd_en = 0.
- ack while rdy = 0 is ignored.
- With N = 1, sel and ptr are constant 0.
- Reset mid-BUSY: the returns to IDLE, no fwd_done pulse is generated, and the pipeline is flushed.
- Core index i maps to bit i of all vectors; there is no custom tag encoding.

Decomposition:
- Shared package fwd_arb_pkg:
  - state encoding (IDLE/OFFER/BUSY);
  - MODE constants MODE_FIXED = 0, MODE_RR = 1, MODE_ORDERED = 2;
  - CLOG2 function, with width max(1, CLOG2(N)).
- One sub-module, rr_pick:
  - inputs: req[N], ptr, mode;
  - outputs: found, idx;
  - purely combinational; instantiated once.

Test Plan:
1. MODE 0, N = 4: rdy_for_fwd = 4'b1010 → rdy at cycle +1, sel = 1. ack → rdy_for_fwd_ack = 4'b0010 for 1 cycle. done → fwd_done = 4'b0010.
2. MODE 1, N = 4: all cores held ready for 8 packets → service order 0, 1, 2, 3, 0, 1, 2, 3; ptr wraps 3 → 0.
3. MODE 2, N = 4, ptr = 2, rdy_for_fwd = 4'b0001 → no rdy. Then raise bit 2 → rdy next cycle, sel = 2.
4. BUSY with sel = 3, rd_en = 1, addr = 0x5A → fwd_rd_en = 4'b1000, fwd_addr = 0x5A. With RD_LAT = 2, core 3 valid with data 0xDEADBEEF → rd_data = 0xDEADBEEF, rd_data_vld = 1 exactly 2 cycles later. No rd_data_vld after leaving BUSY.
5. OFFER on core 1, rdy_for_fwd[1] drops before ack → back to IDLE, no ack pulse. ack and done asserted together in OFFER → ack taken, fwd_done = 0.
6. rst asserted in BUSY → next cycle: state IDLE, all outputs 0, ptr = 0, pipeline empty.
